// File: rtl/branch_predictor_if.sv
// Fetch/resolve/redirect bundle between the MIPS pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic                fetch_valid;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                predict_taken;
    logic                resolve_valid;
    logic                stall;
    logic [PC_WIDTH-1:0] resolve_pc;
    logic                resolve_is_bne;
    logic                inputs_not_equal;
    logic                resolve_predicted;
    logic [PC_WIDTH-1:0] resolve_target;
    logic [PC_WIDTH-1:0] resolve_fallthrough;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [31:0]         branch_count;
    logic [31:0]         mispredict_count;

    modport master (
        output fetch_valid, fetch_pc,
        output resolve_valid, stall, resolve_pc, resolve_is_bne,
        output inputs_not_equal, resolve_predicted,
        output resolve_target, resolve_fallthrough,
        input  predict_taken, redirect_valid, redirect_pc,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  resolve_valid, stall, resolve_pc, resolve_is_bne,
        input  inputs_not_equal, resolve_predicted,
        input  resolve_target, resolve_fallthrough,
        output predict_taken, redirect_valid, redirect_pc,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter BHT with ID-stage BEQ/BNE resolution and redirect.
// Optional macro BHT_UPDATE_BYPASS_EN forwards a same-cycle update to the fetch read.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clock,
    input  logic                reset,
    branch_predictor_if.slave   bus
);
    localparam int DEPTH = 2 ** INDEX_BITS;

    logic [1:0]            table_q [DEPTH];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] resolve_idx;
    logic                  fire;
    logic                  taken;
    logic                  mispredict;
    logic [1:0]            cur_ctr;
    logic [1:0]            new_ctr;
    logic                  unused_pc_bits;

    assign fetch_idx   = bus.fetch_pc[INDEX_BITS+1:2];
    assign resolve_idx = bus.resolve_pc[INDEX_BITS+1:2];
    assign fire        = bus.resolve_valid & ~bus.stall;
    assign taken       = bus.resolve_is_bne ? bus.inputs_not_equal
                                            : ~bus.inputs_not_equal;
    assign mispredict  = fire & (taken != bus.resolve_predicted);
    assign cur_ctr     = table_q[resolve_idx];

    // PC bits outside the index field never affect the table.
    assign unused_pc_bits = ^{bus.fetch_pc[1:0],
                              bus.fetch_pc[PC_WIDTH-1:INDEX_BITS+2],
                              bus.resolve_pc[1:0],
                              bus.resolve_pc[PC_WIDTH-1:INDEX_BITS+2]};

    // Saturating increment on taken, decrement on not-taken.
    always_comb begin
        new_ctr = cur_ctr;
        if (taken) begin
            if (cur_ctr != 2'b11) new_ctr = cur_ctr + 2'd1;
        end else begin
            if (cur_ctr != 2'b00) new_ctr = cur_ctr - 2'd1;
        end
    end

    // Fetch-side prediction from the table MSB.
    always_comb begin
`ifdef BHT_UPDATE_BYPASS_EN
        if (fire && (fetch_idx == resolve_idx))
            bus.predict_taken = bus.fetch_valid & new_ctr[1];
        else
            bus.predict_taken = bus.fetch_valid & table_q[fetch_idx][1];
`else
        bus.predict_taken = bus.fetch_valid & table_q[fetch_idx][1];
`endif
    end

    // Table training; all entries reset to weak-not-taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
        end else if (fire) begin
            table_q[resolve_idx] <= new_ctr;
        end
    end

    // Registered redirect pulse; redirect_pc holds between mispredicts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else begin
            bus.redirect_valid <= mispredict;
            if (mispredict)
                bus.redirect_pc <= taken ? bus.resolve_target
                                         : bus.resolve_fallthrough;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            if (fire && (bus.branch_count != 32'hFFFF_FFFF))
                bus.branch_count <= bus.branch_count + 32'd1;
            if (mispredict && (bus.mispredict_count != 32'hFFFF_FFFF))
                bus.mispredict_count <= bus.mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a behavioural model.
// Define BHT_UPDATE_BYPASS_EN consistently for RTL and bench.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_WIDTH(32)) bif ();

    branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    int          nvec = 0;
    int          nerr = 0;
    int          m_ctr [64];
    int unsigned m_bc;
    int unsigned m_mc;
    bit          m_rv;
    logic [31:0] m_rpc;
    int          pulses;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_bc  = 0;
        m_mc  = 0;
        m_rv  = 0;
        m_rpc = 0;
    endtask

    // One clock: drive at negedge, check prediction, clock, check registered outputs.
    task automatic cycle(input bit fv, input logic [31:0] fpc,
                         input bit rv, input bit st, input bit bne,
                         input bit ne, input bit pred,
                         input logic [31:0] tgt, input logic [31:0] ft);
        bit fire, tk;
        int fi, ri, nxt, shown;
        bif.fetch_valid         = fv;
        bif.fetch_pc            = fpc;
        bif.resolve_valid       = rv;
        bif.stall               = st;
        bif.resolve_pc          = fpc ^ 32'h0;
        bif.resolve_is_bne      = bne;
        bif.inputs_not_equal    = ne;
        bif.resolve_predicted   = pred;
        bif.resolve_target      = tgt;
        bif.resolve_fallthrough = ft;
        fire = rv && !st;
        tk   = bne ? ne : !ne;
        fi   = idx_of(fpc);
        ri   = fi;
        nxt  = tk ? ((m_ctr[ri] + 1 > 3) ? 3 : m_ctr[ri] + 1)
                  : ((m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1);
        shown = m_ctr[fi];
`ifdef BHT_UPDATE_BYPASS_EN
        if (fire) shown = nxt;
`endif
        #1;
        check("predict_taken", 32'(bif.predict_taken),
              32'(fv && shown >= 2));
        if (fire) begin
            m_ctr[ri] = nxt;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (tk != pred) begin
                if (m_mc != 32'hFFFF_FFFF) m_mc++;
                m_rpc = tk ? tgt : ft;
            end
        end
        m_rv = fire && (tk != pred);
        @(posedge clk);
        #1;
        check("redirect_valid", 32'(bif.redirect_valid), 32'(m_rv));
        check("redirect_pc", bif.redirect_pc, m_rpc);
        check("branch_count", bif.branch_count, m_bc);
        check("mispredict_count", bif.mispredict_count, m_mc);
        if (bif.redirect_valid) pulses++;
        @(negedge clk);
    endtask

    // Separate fetch/resolve PCs for the same-index and random phases.
    task automatic cycle2(input bit fv, input logic [31:0] fpc,
                          input bit rv, input bit st,
                          input logic [31:0] rpc, input bit bne,
                          input bit ne, input bit pred,
                          input logic [31:0] tgt, input logic [31:0] ft);
        bit fire, tk;
        int fi, ri, nxt, shown;
        bif.fetch_valid         = fv;
        bif.fetch_pc            = fpc;
        bif.resolve_valid       = rv;
        bif.stall               = st;
        bif.resolve_pc          = rpc;
        bif.resolve_is_bne      = bne;
        bif.inputs_not_equal    = ne;
        bif.resolve_predicted   = pred;
        bif.resolve_target      = tgt;
        bif.resolve_fallthrough = ft;
        fire = rv && !st;
        tk   = bne ? ne : !ne;
        fi   = idx_of(fpc);
        ri   = idx_of(rpc);
        nxt  = tk ? ((m_ctr[ri] + 1 > 3) ? 3 : m_ctr[ri] + 1)
                  : ((m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1);
        shown = m_ctr[fi];
`ifdef BHT_UPDATE_BYPASS_EN
        if (fire && fi == ri) shown = nxt;
`endif
        #1;
        check("predict_taken", 32'(bif.predict_taken),
              32'(fv && shown >= 2));
        if (fire) begin
            m_ctr[ri] = nxt;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (tk != pred) begin
                if (m_mc != 32'hFFFF_FFFF) m_mc++;
                m_rpc = tk ? tgt : ft;
            end
        end
        m_rv = fire && (tk != pred);
        @(posedge clk);
        #1;
        check("redirect_valid", 32'(bif.redirect_valid), 32'(m_rv));
        check("redirect_pc", bif.redirect_pc, m_rpc);
        check("branch_count", bif.branch_count, m_bc);
        check("mispredict_count", bif.mispredict_count, m_mc);
        if (bif.redirect_valid) pulses++;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] fpc);
        cycle2(1, fpc, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] bpc;
        int bc0, p0;
        model_reset();
        pulses = 0;
        bif.fetch_valid = 0; bif.fetch_pc = 0; bif.resolve_valid = 0;
        bif.stall = 0; bif.resolve_pc = 0; bif.resolve_is_bne = 0;
        bif.inputs_not_equal = 0; bif.resolve_predicted = 0;
        bif.resolve_target = 0; bif.resolve_fallthrough = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_redirect_valid", 32'(bif.redirect_valid), 32'd0);
        check("rst_branch_count", bif.branch_count, 32'd0);
        check("rst_mispredict_count", bif.mispredict_count, 32'd0);
        idle(32'h0040_0000);

        // BEQ taken while predicted not-taken.
        bpc = 32'h0040_0010;
        cycle(0, bpc, 1, 0, 0, 0, 0, 32'h0040_0040, 32'h0040_0014);
        check("tp_redirect_pc", bif.redirect_pc, 32'h0040_0040);
        idle(bpc);
        check("tp_predict_after", 32'(bif.predict_taken), 32'd1);

        // Saturate up then down with a BNE.
        bpc = 32'h0040_0020;
        repeat (3) cycle(1, bpc, 1, 0, 1, 1, 1, 32'h0040_0100, 32'h0040_0024);
        check("sat_hi_model", 32'(m_ctr[idx_of(bpc)]), 32'd3);
        repeat (5) cycle(1, bpc, 1, 0, 1, 0, 0, 32'h0040_0100, 32'h0040_0024);
        idle(bpc);
        check("sat_lo_predict", 32'(bif.predict_taken), 32'd0);

        // Stalled resolution: one update, one pulse.
        bc0 = int'(bif.branch_count);
        p0  = pulses;
        bpc = 32'h0040_0030;
        repeat (3) cycle(0, bpc, 1, 1, 0, 0, 0, 32'h0040_0200, 32'h0040_0034);
        cycle(0, bpc, 1, 0, 0, 0, 0, 32'h0040_0200, 32'h0040_0034);
        idle(32'h0);
        check("stall_branch_delta", bif.branch_count - 32'(bc0), 32'd1);
        check("stall_pulses", 32'(pulses - p0), 32'd1);

        // Same-index fetch and not-taken resolve with counter at 10.
        bpc = 32'h0040_0050;
        cycle(0, bpc, 1, 0, 0, 0, 1, 32'h0, 32'h0);
        check("byp_setup", 32'(m_ctr[idx_of(bpc)]), 32'd2);
        cycle2(1, bpc, 1, 0, bpc + 32'h1000, 0, 1, 1, 32'h0, 32'h0040_0054);

        // Randomized traffic over a few indices to force aliasing and saturation.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] fp, rp;
            fp = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2);
            rp = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2)
                 | (32'($urandom_range(0, 3)) << 8);
            if (n % 7 == 0) rp = fp;
            cycle2($urandom_range(0, 1), fp,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rp,
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom, $urandom);
        end

        // Mispredicting fire, then asynchronous reset before the pulse ends.
        cycle(0, 32'h0040_0060, 1, 0, 0, 0, 0, 32'h0040_0abc, 32'h0040_0064);
        check("prer_redirect_valid", 32'(bif.redirect_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("ar_redirect_valid", 32'(bif.redirect_valid), 32'd0);
        check("ar_redirect_pc", bif.redirect_pc, 32'd0);
        check("ar_branch_count", bif.branch_count, 32'd0);
        check("ar_mispredict_count", bif.mispredict_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) idle(32'h0040_0000 | 32'(i << 2));
        // A single taken fire must flip each 01 entry to predict taken.
        for (int i = 0; i < 64; i += 9) begin
            bpc = 32'h0040_0000 | 32'(i << 2);
            cycle(0, bpc, 1, 0, 0, 0, 1, 32'h0, 32'h0);
            idle(bpc);
            check("post_rst_weak_nt", 32'(bif.predict_taken), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
